// File: rtl/nest_pkg.sv
// Shared definitions for the keyword nesting checker: keyword bytes and lengths,
// kind encoding, error codes and tokenizer states.
package nest_pkg;

  // Keyword bytes are packed first-character-in-MSB and zero padded to five characters.
  localparam logic [39:0] KW_BEGIN  = 40'h62_65_67_69_6E;
  localparam logic [39:0] KW_END    = 40'h65_6E_64_00_00;
  localparam logic [39:0] KW_FORK   = 40'h66_6F_72_6B_00;
  localparam logic [39:0] KW_JOIN   = 40'h6A_6F_69_6E_00;

  localparam logic [2:0]  LEN_BEGIN = 3'd5;
  localparam logic [2:0]  LEN_END   = 3'd3;
  localparam logic [2:0]  LEN_FORK  = 3'd4;
  localparam logic [2:0]  LEN_JOIN  = 3'd4;

  localparam logic [1:0]  KW_IDX_BEGIN = 2'd0;
  localparam logic [1:0]  KW_IDX_END   = 2'd1;
  localparam logic [1:0]  KW_IDX_FORK  = 2'd2;
  localparam logic [1:0]  KW_IDX_JOIN  = 2'd3;

  localparam logic KIND_BLOCK = 1'b0;
  localparam logic KIND_FORK  = 1'b1;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_MISMATCH  = 2'd2,
    ERR_OVERFLOW  = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    TOK_SEP  = 2'd0,
    TOK_WORD = 2'd1,
    TOK_JUNK = 2'd2
  } tok_state_e;

  function automatic logic [39:0] kw_bytes(input logic [1:0] k);
    case (k)
      KW_IDX_BEGIN: kw_bytes = KW_BEGIN;
      KW_IDX_END:   kw_bytes = KW_END;
      KW_IDX_FORK:  kw_bytes = KW_FORK;
      default:      kw_bytes = KW_JOIN;
    endcase
  endfunction

  function automatic logic [2:0] kw_len(input logic [1:0] k);
    case (k)
      KW_IDX_BEGIN: kw_len = LEN_BEGIN;
      KW_IDX_END:   kw_len = LEN_END;
      KW_IDX_FORK:  kw_len = LEN_FORK;
      default:      kw_len = LEN_JOIN;
    endcase
  endfunction

  function automatic logic [7:0] kw_char(input logic [1:0] k, input logic [2:0] i);
    logic [39:0] sh;
    sh = kw_bytes(k) << {i, 3'b000};
    return sh[39:32];
  endfunction

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) begin
      return c | 8'h20;
    end else begin
      return c;
    end
  endfunction

  function automatic logic is_delim(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A);
  endfunction

endpackage

// File: rtl/nest_kind_stack.sv
// MAX_DEPTH x 1-bit LIFO of keyword kinds; bit n holds the kind pushed at depth n.
module nest_kind_stack #(
  parameter  int MAX_DEPTH = 16,
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic               push_kind,
  output logic               top,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  localparam logic [DEPTH_W-1:0]   FULL_LVL = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0]   ONE      = DEPTH_W'(1);
  localparam logic [MAX_DEPTH-1:0] BIT0     = MAX_DEPTH'(1);

  logic [MAX_DEPTH-1:0] mem_q, mem_d, slot_s, top_vec_s;
  logic [DEPTH_W-1:0]   depth_q, depth_d;

  // Next stack contents and occupancy.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    slot_s  = BIT0 << depth_q;
    if (clear) begin
      mem_d   = '0;
      depth_d = '0;
    end else if (push && !full) begin
      mem_d   = push_kind ? (mem_q | slot_s) : (mem_q & ~slot_s);
      depth_d = depth_q + ONE;
    end else if (pop && !empty) begin
      depth_d = depth_q - ONE;
    end else begin
      depth_d = depth_q;
    end
  end

  // Stack state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      depth_q <= '0;
    end else begin
      mem_q   <= mem_d;
      depth_q <= depth_d;
    end
  end

  assign top_vec_s = mem_q >> (depth_q - ONE);
  assign top       = top_vec_s[0];
  assign depth     = depth_q;
  assign full      = (depth_q == FULL_LVL);
  assign empty     = (depth_q == '0);

endmodule

// File: rtl/nest_keyword_checker.sv
// Streaming begin/end + fork/join nesting checker with a kind stack and first-error latch.
// Optional NEST_ERR_POS_EN adds a word counter and the err_pos port.
module nest_keyword_checker
  import nest_pkg::*;
#(
  parameter  int MAX_DEPTH = 16,
`ifdef NEST_ERR_POS_EN
  parameter  int POS_W     = 16,
`endif
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  input  logic               flush,
  input  logic               clear,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               error,
  output logic [1:0]         err_code
`ifdef NEST_ERR_POS_EN
  ,
  output logic [POS_W-1:0]   err_pos
`endif
);

  tok_state_e         tok_q, tok_d, w_tok_s;
  logic [3:0]         mask_q, mask_d, w_mask_s, cand_s, hit_s;
  logic [2:0]         idx_q, idx_d, w_idx_s;
  logic [7:0]         ch_s;
  logic               delim_s, append_s, commit_s;
  logic               opener_s, closer_s, kind_s;
  logic               push_s, pop_s, top_s, full_s, empty_s;
  logic [DEPTH_W-1:0] depth_s;
  err_code_e          err_q, err_d;

  // Tokenizer: w_* is the word after this cycle's character is appended.
  always_comb begin
    ch_s     = fold_case(in);
    delim_s  = is_delim(in);
    append_s = in_valid && !delim_s;
    cand_s   = '0;
    w_tok_s  = tok_q;
    w_mask_s = mask_q;
    w_idx_s  = idx_q;
    if (append_s) begin
      for (int k = 0; k < 4; k++) begin
        if (tok_q == TOK_SEP) begin
          cand_s[k] = (kw_char(2'(k), 3'd0) == ch_s);
        end else begin
          cand_s[k] = mask_q[k] && (idx_q < kw_len(2'(k))) && (kw_char(2'(k), idx_q) == ch_s);
        end
      end
      w_mask_s = cand_s;
      w_idx_s  = (tok_q == TOK_SEP) ? 3'd1 : ((idx_q == 3'd7) ? 3'd7 : idx_q + 3'd1);
      w_tok_s  = (cand_s == 4'd0) ? TOK_JUNK : TOK_WORD;
    end else begin
      w_tok_s  = tok_q;
    end

    commit_s = ((in_valid && delim_s) || flush) && (w_tok_s != TOK_SEP);
    for (int k = 0; k < 4; k++) begin
      hit_s[k] = w_mask_s[k] && (w_idx_s == kw_len(2'(k)));
    end

    if (clear || commit_s || (in_valid && delim_s)) begin
      tok_d  = TOK_SEP;
      mask_d = '0;
      idx_d  = '0;
    end else begin
      tok_d  = w_tok_s;
      mask_d = w_mask_s;
      idx_d  = w_idx_s;
    end
  end

  // Commit: push/pop the kind stack or latch the first error; frozen once an error is held.
  always_comb begin
    opener_s = hit_s[KW_IDX_BEGIN] | hit_s[KW_IDX_FORK];
    closer_s = hit_s[KW_IDX_END] | hit_s[KW_IDX_JOIN];
    kind_s   = (hit_s[KW_IDX_FORK] | hit_s[KW_IDX_JOIN]) ? KIND_FORK : KIND_BLOCK;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    err_d    = err_q;
    if (clear) begin
      err_d = ERR_NONE;
    end else if (commit_s && (err_q == ERR_NONE)) begin
      if (opener_s) begin
        if (full_s) begin
          err_d = ERR_OVERFLOW;
        end else begin
          push_s = 1'b1;
        end
      end else if (closer_s) begin
        if (empty_s) begin
          err_d = ERR_UNDERFLOW;
        end else if (top_s != kind_s) begin
          err_d = ERR_MISMATCH;
        end else begin
          pop_s = 1'b1;
        end
      end else begin
        push_s = 1'b0;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Tokenizer and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_q  <= TOK_SEP;
      mask_q <= '0;
      idx_q  <= '0;
      err_q  <= ERR_NONE;
    end else begin
      tok_q  <= tok_d;
      mask_q <= mask_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
    end
  end

  nest_kind_stack #(
    .MAX_DEPTH (MAX_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push_s),
    .pop       (pop_s),
    .push_kind (kind_s),
    .top       (top_s),
    .depth     (depth_s),
    .full      (full_s),
    .empty     (empty_s)
  );

`ifdef NEST_ERR_POS_EN
  logic [POS_W-1:0] pos_q, pos_d, err_pos_q, err_pos_d;

  // Word counter and capture of the index of the first erroring word.
  always_comb begin
    pos_d     = pos_q;
    err_pos_d = err_pos_q;
    if (clear) begin
      pos_d     = '0;
      err_pos_d = '0;
    end else begin
      if (commit_s && (pos_q != '1)) begin
        pos_d = pos_q + POS_W'(1);
      end else begin
        pos_d = pos_q;
      end
      if ((err_q == ERR_NONE) && (err_d != ERR_NONE)) begin
        err_pos_d = pos_q;
      end else begin
        err_pos_d = err_pos_q;
      end
    end
  end

  // Word counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q     <= '0;
      err_pos_q <= '0;
    end else begin
      pos_q     <= pos_d;
      err_pos_q <= err_pos_d;
    end
  end

  assign err_pos = err_pos_q;
`endif

  assign depth    = depth_s;
  assign error    = (err_q != ERR_NONE);
  assign err_code = err_q;
  assign result   = (err_q == ERR_NONE) && (depth_s == '0);

endmodule
